// File: rtl/torus_io_bank_pkg.sv
// ============================================================================
// torus_pkg : shared constants and helpers for the torus CGRA I/O buffer bank
// Revision  : 1.0
// ============================================================================
`default_nettype none

package torus_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int MAX_CH     = 8;

  // Occupancy needs one bit more than the pointer so that DEPTH itself is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/torus_io_bank_if.sv
// ============================================================================
// torus_io_bank_if : system-side and PE-side bus bundle of the I/O buffer bank
// Revision         : 1.0
// ============================================================================
`default_nettype none

interface torus_io_bank_if
  import torus_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DEPTH  = 16
) ();

  localparam int CW = cnt_width(DEPTH);

  logic                     CGRA_Ena;
  logic                     Clear;
  logic [NUM_CH-1:0]        Sys_Ld_Valid;
  logic [NUM_CH*DWIDTH-1:0] Sys_Ld_Data;
  logic [NUM_CH-1:0]        Sys_Ld_Ready;
  logic [NUM_CH*DWIDTH-1:0] PE_Load;
  logic [NUM_CH-1:0]        PE_Load_Pop;
  logic [NUM_CH*DWIDTH-1:0] PE_Store;
  logic [NUM_CH-1:0]        PE_Store_Push;
  logic [NUM_CH-1:0]        Sys_St_Valid;
  logic [NUM_CH*DWIDTH-1:0] Sys_St_Data;
  logic [NUM_CH-1:0]        Sys_St_Ready;
  logic [NUM_CH*CW-1:0]     Ld_Count;
  logic [NUM_CH*CW-1:0]     St_Count;
  logic [NUM_CH-1:0]        Err_Underflow;
  logic [NUM_CH-1:0]        Err_Overflow;

  modport slave (
    input  CGRA_Ena, Clear, Sys_Ld_Valid, Sys_Ld_Data, PE_Load_Pop,
           PE_Store, PE_Store_Push, Sys_St_Ready,
    output Sys_Ld_Ready, PE_Load, Sys_St_Valid, Sys_St_Data,
           Ld_Count, St_Count, Err_Underflow, Err_Overflow
  );

  modport master (
    output CGRA_Ena, Clear, Sys_Ld_Valid, Sys_Ld_Data, PE_Load_Pop,
           PE_Store, PE_Store_Push, Sys_St_Ready,
    input  Sys_Ld_Ready, PE_Load, Sys_St_Valid, Sys_St_Data,
           Ld_Count, St_Count, Err_Underflow, Err_Overflow
  );

endinterface

`default_nettype wire

// File: rtl/torus_io_bank_io_fifo.sv
// ============================================================================
// io_fifo : single show-ahead FIFO with registered head and error strobes
// Revision: 1.0
// ============================================================================
`default_nettype none

module io_fifo
  import torus_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int CW     = cnt_width(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              clr,
  input  wire logic              wr_en,
  input  wire logic [DWIDTH-1:0] wr_data,
  input  wire logic              rd_en,
  output logic      [DWIDTH-1:0] rd_data,
  output logic      [CW-1:0]     count,
  output logic                   full,
  output logic                   empty,
  output logic                   err_ovf,
  output logic                   err_unf
);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [DWIDTH-1:0] r_head;

  logic          w_full;
  logic          w_empty;
  logic          w_do_wr;
  logic          w_do_rd;
  logic [AW-1:0] w_rptr_nxt;

  // Full/empty come from the count at the start of the cycle only.
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_do_wr    = wr_en & ~w_full & ~clr;
  assign w_do_rd    = rd_en & ~w_empty & ~clr;
  assign w_rptr_nxt = r_rptr + AW'(1);

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_do_rd) begin
        r_rptr <= w_rptr_nxt;
      end
      r_count <= r_count + CW'(w_do_wr) - CW'(w_do_rd);
      // The entry behind the head is already in RAM when count > 1; at count 1 it
      // can only be the word landing this cycle. Popping the last word holds the head.
      if (w_do_rd) begin
        if (r_count > CW'(1)) begin
          r_head <= r_mem[w_rptr_nxt];
        end else if (w_do_wr) begin
          r_head <= wr_data;
        end
      end else if (w_do_wr && w_empty) begin
        r_head <= wr_data;
      end
    end
  end

  assign rd_data = r_head;
  assign count   = r_count;
  assign full    = w_full;
  assign empty   = w_empty;
  assign err_ovf = wr_en & w_full;
  assign err_unf = rd_en & w_empty;

endmodule

`default_nettype wire

// File: rtl/torus_io_bank.sv
// ============================================================================
// torus_io_bank : per-channel load/store FIFO bank between system and I/O PEs
// Revision      : 1.0
// ============================================================================
`default_nettype none

module torus_io_bank
  import torus_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DEPTH  = 16
) (
  input  wire logic        Clk,
  input  wire logic        Reset,
  torus_io_bank_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic w_ena;
  logic w_clr;

  assign w_ena = bus.CGRA_Ena;
  assign w_clr = bus.Clear;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DWIDTH-1:0] w_ld_head;
      logic [DWIDTH-1:0] w_st_head;
      logic [CW-1:0]     w_ld_cnt;
      logic [CW-1:0]     w_st_cnt;
      logic              w_ld_full;
      logic              w_ld_empty_unused;
      logic              w_ld_ovf_unused;
      logic              w_ld_unf;
      logic              w_st_full_unused;
      logic              w_st_empty;
      logic              w_st_ovf;
      logic              w_st_unf_unused;
      logic              w_ld_wr;
      logic              w_ld_rd;
      logic              w_st_wr;
      logic              w_st_rd;
      logic              r_unf;
      logic              r_ovf;

      // PE-side strobes only count while the array is running.
      assign w_ld_wr = bus.Sys_Ld_Valid[c] & ~w_ld_full;
      assign w_ld_rd = w_ena & bus.PE_Load_Pop[c];
      assign w_st_wr = w_ena & bus.PE_Store_Push[c];
      assign w_st_rd = bus.Sys_St_Ready[c] & ~w_st_empty;

      io_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .CW     (CW)
      ) u_ld_fifo (
        .clk     (Clk),
        .rst     (Reset),
        .clr     (w_clr),
        .wr_en   (w_ld_wr),
        .wr_data (bus.Sys_Ld_Data[c*DWIDTH +: DWIDTH]),
        .rd_en   (w_ld_rd),
        .rd_data (w_ld_head),
        .count   (w_ld_cnt),
        .full    (w_ld_full),
        .empty   (w_ld_empty_unused),
        .err_ovf (w_ld_ovf_unused),
        .err_unf (w_ld_unf)
      );

      io_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .CW     (CW)
      ) u_st_fifo (
        .clk     (Clk),
        .rst     (Reset),
        .clr     (w_clr),
        .wr_en   (w_st_wr),
        .wr_data (bus.PE_Store[c*DWIDTH +: DWIDTH]),
        .rd_en   (w_st_rd),
        .rd_data (w_st_head),
        .count   (w_st_cnt),
        .full    (w_st_full_unused),
        .empty   (w_st_empty),
        .err_ovf (w_st_ovf),
        .err_unf (w_st_unf_unused)
      );

      // Sticky until Reset or Clear; Clear wins over a same-cycle error.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          r_unf <= 1'b0;
          r_ovf <= 1'b0;
        end else if (w_clr) begin
          r_unf <= 1'b0;
          r_ovf <= 1'b0;
        end else begin
          r_unf <= r_unf | w_ld_unf;
          r_ovf <= r_ovf | w_st_ovf;
        end
      end

      assign bus.Sys_Ld_Ready[c]               = ~w_ld_full;
      assign bus.PE_Load[c*DWIDTH +: DWIDTH]   = w_ld_head;
      assign bus.Sys_St_Valid[c]               = ~w_st_empty;
      assign bus.Sys_St_Data[c*DWIDTH +: DWIDTH] = w_st_head;
      assign bus.Ld_Count[c*CW +: CW]          = w_ld_cnt;
      assign bus.St_Count[c*CW +: CW]          = w_st_cnt;
      assign bus.Err_Underflow[c]              = r_unf;
      assign bus.Err_Overflow[c]               = r_ovf;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_torus_io_bank.sv
// ============================================================================
// tb_torus_io_bank : directed self-checking bench for torus_io_bank
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_torus_io_bank;

  localparam int NUM_CH = 2;
  localparam int DW     = 32;
  localparam int DEPTH  = 16;
  localparam int CW     = 5;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  torus_io_bank_if #(.NUM_CH(NUM_CH), .DWIDTH(DW), .DEPTH(DEPTH)) bus ();

  torus_io_bank #(.NUM_CH(NUM_CH), .DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] ld_cnt(input int c);
    return bus.Ld_Count[c*CW +: CW];
  endfunction
  function automatic logic [CW-1:0] st_cnt(input int c);
    return bus.St_Count[c*CW +: CW];
  endfunction
  function automatic logic [DW-1:0] pe_load(input int c);
    return bus.PE_Load[c*DW +: DW];
  endfunction
  function automatic logic [DW-1:0] st_data(input int c);
    return bus.Sys_St_Data[c*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.CGRA_Ena      = 1'b1;
    bus.Clear         = 1'b0;
    bus.Sys_Ld_Valid  = '0;
    bus.Sys_Ld_Data   = '0;
    bus.PE_Load_Pop   = '0;
    bus.PE_Store      = '0;
    bus.PE_Store_Push = '0;
    bus.Sys_St_Ready  = '0;
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (bus.Ld_Count !== '0 || bus.St_Count !== '0) begin
      failures++;
      $display("FAIL %s counts: ld=%h st=%h expected 0", tag, bus.Ld_Count, bus.St_Count);
    end
    checks++;
    if (bus.Err_Underflow !== 2'b00 || bus.Err_Overflow !== 2'b00) begin
      failures++;
      $display("FAIL %s errors: unf=%b ovf=%b expected 00", tag, bus.Err_Underflow, bus.Err_Overflow);
    end
    checks++;
    if (bus.PE_Load !== '0 || bus.Sys_St_Data !== '0) begin
      failures++;
      $display("FAIL %s heads: pe_load=%h st_data=%h expected 0", tag, bus.PE_Load, bus.Sys_St_Data);
    end
    checks++;
    if (bus.Sys_St_Valid !== 2'b00 || bus.Sys_Ld_Ready !== 2'b11) begin
      failures++;
      $display("FAIL %s handshake: st_valid=%b ld_ready=%b expected 00/11", tag, bus.Sys_St_Valid, bus.Sys_Ld_Ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check_reset_state("reset");
  endtask

  task automatic test_load_stream();
    logic [DW-1:0] exp;
    for (int k = 0; k < 4; k++) begin
      bus.Sys_Ld_Valid[0]     = 1'b1;
      bus.Sys_Ld_Data[0+:DW]  = 32'hA0 + 32'(k);
      bus.PE_Load_Pop[0]      = (k != 0);
      tick();
      exp = 32'hA0 + 32'(k);
      checks++;
      if (pe_load(0) !== exp || ld_cnt(0) !== 5'd1) begin
        failures++;
        $display("FAIL load_stream[%0d]: pe_load=%h cnt=%0d expected %h/1", k, pe_load(0), ld_cnt(0), exp);
      end
    end
    bus.Sys_Ld_Valid[0] = 1'b0;
    bus.PE_Load_Pop[0]  = 1'b1;
    tick();
    bus.PE_Load_Pop[0]  = 1'b0;
    checks++;
    if (ld_cnt(0) !== 5'd0 || bus.Err_Underflow !== 2'b00 || pe_load(0) !== 32'hA3) begin
      failures++;
      $display("FAIL load_drain: cnt=%0d unf=%b pe_load=%h expected 0/00/a3", ld_cnt(0), bus.Err_Underflow, pe_load(0));
    end
  endtask

  task automatic test_load_full();
    for (int i = 0; i < DEPTH; i++) begin
      bus.Sys_Ld_Valid[1]     = 1'b1;
      bus.Sys_Ld_Data[DW+:DW] = 32'h100 + 32'(i);
      tick();
    end
    checks++;
    if (bus.Sys_Ld_Ready[1] !== 1'b0 || ld_cnt(1) !== 5'd16) begin
      failures++;
      $display("FAIL load_full: ready=%b cnt=%0d expected 0/16", bus.Sys_Ld_Ready[1], ld_cnt(1));
    end
    bus.Sys_Ld_Data[DW+:DW] = 32'h1FF;
    tick();
    bus.Sys_Ld_Valid[1] = 1'b0;
    checks++;
    if (ld_cnt(1) !== 5'd16 || pe_load(1) !== 32'h100) begin
      failures++;
      $display("FAIL load_17th: cnt=%0d pe_load=%h expected 16/100", ld_cnt(1), pe_load(1));
    end
    bus.PE_Load_Pop[1] = 1'b1;
    tick();
    checks++;
    if (bus.Sys_Ld_Ready[1] !== 1'b1 || ld_cnt(1) !== 5'd15 || pe_load(1) !== 32'h101) begin
      failures++;
      $display("FAIL load_pop_ready: ready=%b cnt=%0d pe_load=%h expected 1/15/101", bus.Sys_Ld_Ready[1], ld_cnt(1), pe_load(1));
    end
    repeat (15) tick();
    bus.PE_Load_Pop[1] = 1'b0;
    checks++;
    if (ld_cnt(1) !== 5'd0 || pe_load(1) !== 32'h10F || bus.Err_Underflow[1] !== 1'b0) begin
      failures++;
      $display("FAIL load_full_drain: cnt=%0d pe_load=%h unf=%b expected 0/10f/0", ld_cnt(1), pe_load(1), bus.Err_Underflow[1]);
    end
  endtask

  task automatic test_store_enable();
    bus.CGRA_Ena         = 1'b0;
    bus.PE_Store[0+:DW]  = 32'h55;
    bus.PE_Store_Push[0] = 1'b1;
    tick();
    checks++;
    if (st_cnt(0) !== 5'd0 || bus.Sys_St_Valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL store_gated: cnt=%0d valid=%b expected 0/0", st_cnt(0), bus.Sys_St_Valid[0]);
    end
    bus.CGRA_Ena = 1'b1;
    tick();
    bus.PE_Store_Push[0] = 1'b0;
    checks++;
    if (bus.Sys_St_Valid[0] !== 1'b1 || st_data(0) !== 32'h55 || st_cnt(0) !== 5'd1) begin
      failures++;
      $display("FAIL store_push: valid=%b data=%h cnt=%0d expected 1/55/1", bus.Sys_St_Valid[0], st_data(0), st_cnt(0));
    end
    bus.Sys_St_Ready[0] = 1'b1;
    tick();
    bus.Sys_St_Ready[0] = 1'b0;
    checks++;
    if (bus.Sys_St_Valid[0] !== 1'b0 || st_cnt(0) !== 5'd0) begin
      failures++;
      $display("FAIL store_pop: valid=%b cnt=%0d expected 0/0", bus.Sys_St_Valid[0], st_cnt(0));
    end
  endtask

  task automatic test_store_overflow();
    logic [DW-1:0] exp;
    bus.PE_Store_Push[0] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.PE_Store[0+:DW] = 32'h200 + 32'(i);
      tick();
    end
    bus.PE_Store[0+:DW] = 32'hDEAD;
    tick();
    bus.PE_Store_Push[0] = 1'b0;
    checks++;
    if (bus.Err_Overflow[0] !== 1'b1 || st_cnt(0) !== 5'd16) begin
      failures++;
      $display("FAIL store_ovf: ovf=%b cnt=%0d expected 1/16", bus.Err_Overflow[0], st_cnt(0));
    end
    bus.Sys_St_Ready[0] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp = 32'h200 + 32'(i);
      checks++;
      if (st_data(0) !== exp || bus.Sys_St_Valid[0] !== 1'b1) begin
        failures++;
        $display("FAIL store_drain[%0d]: data=%h valid=%b expected %h/1", i, st_data(0), bus.Sys_St_Valid[0], exp);
      end
      tick();
    end
    bus.Sys_St_Ready[0] = 1'b0;
    checks++;
    if (st_cnt(0) !== 5'd0 || bus.Sys_St_Valid[0] !== 1'b0 || bus.Err_Overflow[0] !== 1'b1) begin
      failures++;
      $display("FAIL store_after_drain: cnt=%0d valid=%b ovf=%b expected 0/0/1", st_cnt(0), bus.Sys_St_Valid[0], bus.Err_Overflow[0]);
    end
  endtask

  task automatic test_underflow_same_cycle();
    bus.Sys_Ld_Valid[0]    = 1'b1;
    bus.Sys_Ld_Data[0+:DW] = 32'h77;
    bus.PE_Load_Pop[0]     = 1'b1;
    tick();
    bus.Sys_Ld_Valid[0] = 1'b0;
    bus.PE_Load_Pop[0]  = 1'b0;
    checks++;
    if (bus.Err_Underflow[0] !== 1'b1 || ld_cnt(0) !== 5'd1 || pe_load(0) !== 32'h77) begin
      failures++;
      $display("FAIL unf_same_cycle: unf=%b cnt=%0d pe_load=%h expected 1/1/77", bus.Err_Underflow[0], ld_cnt(0), pe_load(0));
    end
  endtask

  task automatic test_clear();
    bus.Sys_Ld_Valid[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.Sys_Ld_Data[0+:DW] = 32'h300 + 32'(i);
      tick();
    end
    checks++;
    if (ld_cnt(0) !== 5'd5) begin
      failures++;
      $display("FAIL clear_setup: cnt=%0d expected 5", ld_cnt(0));
    end
    bus.Clear          = 1'b1;
    bus.PE_Load_Pop[0] = 1'b1;
    tick();
    bus.Clear           = 1'b0;
    bus.Sys_Ld_Valid[0] = 1'b0;
    bus.PE_Load_Pop[0]  = 1'b0;
    checks++;
    if (bus.Ld_Count !== '0 || bus.St_Count !== '0 || bus.Err_Underflow !== 2'b00 || bus.Err_Overflow !== 2'b00) begin
      failures++;
      $display("FAIL clear: ld=%h st=%h unf=%b ovf=%b expected all 0", bus.Ld_Count, bus.St_Count, bus.Err_Underflow, bus.Err_Overflow);
    end
  endtask

  task automatic test_reset_midstream();
    bus.Sys_Ld_Valid       = 2'b11;
    bus.Sys_Ld_Data        = {32'h4444_0001, 32'h4444_0000};
    bus.PE_Store           = {32'h5555_0001, 32'h5555_0000};
    bus.PE_Store_Push      = 2'b11;
    tick();
    tick();
    checks++;
    if (ld_cnt(0) !== 5'd2 || st_cnt(1) !== 5'd2 || pe_load(1) !== 32'h4444_0001) begin
      failures++;
      $display("FAIL midstream_setup: ld0=%0d st1=%0d pe_load1=%h expected 2/2/44440001", ld_cnt(0), st_cnt(1), pe_load(1));
    end
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async_reset");
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
    check_reset_state("post_reset");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_load_stream();
    test_load_full();
    test_store_enable();
    test_store_overflow();
    test_underflow_same_cycle();
    test_clear();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
